// File: rtl/step_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : step_pkg                                                  |
// | Brief    : Shared state encoding, default motion-profile constants   |
// |            and saturating period arithmetic for step_pulse_gen.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package step_pkg;

  // Motion-profile phases; explicit 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEL  = 2'd1,
    ST_CRUISE = 2'd2,
    ST_DECEL  = 2'd3
  } step_state_t;

  localparam int unsigned DEF_MIN_PERIOD = 5000;
  localparam int unsigned DEF_MAX_PERIOD = 50000;
  localparam int unsigned DEF_ACCEL_DEC  = 500;
  localparam int unsigned DEF_PULSE_W    = 4;

  // Move val by delta towards lim (up: clamp at or below lim, down: clamp at
  // or above lim). Also guards against wrap of the unsigned arithmetic.
  function automatic logic [31:0] sat_adj(input logic [31:0] val,
                                          input logic [31:0] delta,
                                          input logic        up,
                                          input logic [31:0] lim);
    logic [32:0] sum;
    logic [31:0] res;
    sum = {1'b0, val} + {1'b0, delta};
    if (up) begin
      res = (sum > {1'b0, lim}) ? lim : sum[31:0];
    end else begin
      res = ((val < delta) || ((val - delta) < lim)) ? lim : (val - delta);
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/step_pulse_stretch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : step_pulse_stretch                                        |
// | Brief    : Widens a one-cycle step event into a PULSE_W-cycle        |
// |            registered step_pulse. A pulse already started always     |
// |            runs to full width unless reset truncates it.             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module step_pulse_stretch
  import step_pkg::*;
#(
  parameter int unsigned PULSE_W = DEF_PULSE_W
) (
  input  logic clk,
  input  logic rst,
  input  logic step_evt,
  output logic step_pulse
);

  localparam int unsigned CNT_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  // Load the remaining-high count on an event, then count down to release.
  always_ff @(posedge clk or negedge rst) begin : p_stretch
    if (!rst) begin
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else if (step_evt) begin
      r_pulse <= 1'b1;
      r_cnt   <= C_CNT_LOAD;
    end else if (r_cnt != '0) begin
      r_cnt   <= r_cnt - C_CNT_ONE;
    end else begin
      r_pulse <= 1'b0;
    end
  end

  assign step_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/step_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : step_pulse_gen                                            |
// | Brief    : Trapezoidal motion-profile generator. Turns a move        |
// |            command into a timed step_pulse train: ramp up from       |
// |            MAX_PERIOD to MIN_PERIOD, cruise, ramp down, stop.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int unsigned STEP_W     = 16,
  parameter int unsigned PER_W      = 24,
  parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int unsigned MAX_PERIOD = DEF_MAX_PERIOD,
  parameter int unsigned ACCEL_DEC  = DEF_ACCEL_DEC,
  parameter int unsigned PULSE_W    = DEF_PULSE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              run_free,
  input  logic              hold_en,
  input  logic [STEP_W-1:0] steps,
  output logic              step_pulse,
  output logic              zero_state,
  output logic              busy,
  output logic              done
);

  localparam logic [PER_W-1:0]  C_MIN_PER = PER_W'(MIN_PERIOD);
  localparam logic [PER_W-1:0]  C_MAX_PER = PER_W'(MAX_PERIOD);
  localparam logic [PER_W-1:0]  C_ONE_PER = PER_W'(1);
  localparam logic [STEP_W-1:0] C_ONE_STP = STEP_W'(1);

  step_state_t       r_state;
  logic [PER_W-1:0]  r_timer;
  logic [PER_W-1:0]  r_period;
  logic [STEP_W-1:0] r_remaining;
  logic [STEP_W-1:0] r_ramp_len;
  logic              r_free;
  logic              r_busy;
  logic              r_done;
  logic              r_zero;

  logic              w_step_evt;
  logic              w_counting;
  logic [STEP_W-1:0] w_rem_new;
  logic [PER_W-1:0]  w_period_up;
  logic [PER_W-1:0]  w_period_dn;

  // A free-running move only starts counting down once it has been told to
  // stop, i.e. once it is decelerating with remaining = ramp_len.
  assign w_step_evt  = (r_state != ST_IDLE) && (r_timer == (r_period - C_ONE_PER));
  assign w_counting  = !r_free || (r_state == ST_DECEL);
  assign w_rem_new   = w_counting ? (r_remaining - C_ONE_STP) : r_remaining;
  assign w_period_up = PER_W'(sat_adj(32'(r_period), 32'(ACCEL_DEC), 1'b1, 32'(MAX_PERIOD)));
  assign w_period_dn = PER_W'(sat_adj(32'(r_period), 32'(ACCEL_DEC), 1'b0, 32'(MIN_PERIOD)));

  // Profile FSM: move acceptance, interval timing, ramp bookkeeping, stop.
  always_ff @(posedge clk or negedge rst) begin : p_fsm
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_period    <= '0;
      r_remaining <= '0;
      r_ramp_len  <= '0;
      r_free      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_zero      <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          r_zero  <= !hold_en;
          if (start && !stop && ((steps != '0) || run_free)) begin
            r_state     <= ST_ACCEL;
            r_period    <= C_MAX_PER;
            r_remaining <= steps;
            r_ramp_len  <= '0;
            r_free      <= run_free;
            r_busy      <= 1'b1;
            r_zero      <= 1'b0;
          end
        end
        default: begin
          r_timer <= r_timer + C_ONE_PER;
          if (w_step_evt) begin
            r_timer     <= '0;
            r_remaining <= w_rem_new;
            if (w_counting && (w_rem_new == '0)) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_zero  <= !hold_en;
            end else if ((r_state != ST_DECEL) && w_counting && (w_rem_new <= r_ramp_len)) begin
              r_state  <= ST_DECEL;
              r_period <= w_period_up;
            end else if (r_state == ST_ACCEL) begin
              r_period <= w_period_dn;
              if (r_ramp_len != '1) begin
                r_ramp_len <= r_ramp_len + C_ONE_STP;
              end
              if (w_period_dn == C_MIN_PER) begin
                r_state <= ST_CRUISE;
              end
            end else if (r_state == ST_DECEL) begin
              r_period <= w_period_up;
            end
          end else if (stop && (r_state != ST_DECEL)) begin
            // Controlled stop: retrace the ramp already climbed. The timer
            // keeps running so the current interval simply stretches.
            if (r_ramp_len == '0) begin
              r_state <= ST_IDLE;
              r_timer <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_zero  <= !hold_en;
            end else begin
              r_state     <= ST_DECEL;
              r_remaining <= r_ramp_len;
              r_period    <= w_period_up;
            end
          end
        end
      endcase
    end
  end

  step_pulse_stretch #(
    .PULSE_W (PULSE_W)
  ) u_stretch (
    .clk        (clk),
    .rst        (rst),
    .step_evt   (w_step_evt),
    .step_pulse (step_pulse)
  );

  assign busy       = r_busy;
  assign done       = r_done;
  assign zero_state = r_zero;

endmodule
`default_nettype wire

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
Trapezoidal motion-profile generator directly upstream of the stepper phase driver. Converts a move command (step count, or free-run) into a timed step_pulse train: accelerate from MAX_PERIOD to MIN_PERIOD, cruise, then decelerate symmetrically to stop. Drives the driver's zero_state to de-energise the coils when idle. One pulse equals one driver state advance; in full-step mode the driver consumes two pulses per motor step.

Parameters:
STEP_W, 16, width of step count and ramp counters
PER_W, 24, width of period and interval timer
MIN_PERIOD, 5000, cruise interval between step events, in clk cycles
MAX_PERIOD, 50000, start/stop interval, in clk cycles
ACCEL_DEC, 500, period change per step during ramps
PULSE_W, 4, step_pulse high time in clk cycles; must be < MIN_PERIOD

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  1-cycle move request, sampled only in IDLE
stop  in  1  controlled-stop request (level, sampled each cycle)
run_free  in  1  latched at start: 1 = run until stop, ignore steps
hold_en  in  1  1 = keep coils energised (zero_state low) while idle
steps  in  STEP_W  pulse count for the move, latched at start
step_pulse  out  1  step clock to the phase driver
zero_state  out  1  1 = driver outputs all-off
busy  out  1  high in any state except IDLE
done  out  1  1-cycle pulse when a move completes

Behaviour:
- Reset (async): state=IDLE, step_pulse=0, busy=0, done=0, zero_state=1. Timer, period, remaining and ramp_len are cleared. A pulse in flight is truncated.
- States: IDLE, ACCEL, CRUISE, DECEL. zero_state = (state==IDLE) && !hold_en, registered.
- IDLE: start accepted when steps!=0 or run_free=1; otherwise it is ignored and no done is produced.
  - If stop and start are sampled in the same cycle, stop wins and start is ignored.
  - On acceptance at cycle N: state=ACCEL, period=MAX_PERIOD, timer=0, remaining=steps, ramp_len=0. busy=1 and zero_state=0 from cycle N+1.
- Interval timer: increments each cycle. The step event is the cycle where timer==period-1; the timer returns to 0 on that cycle.
- First step event is at cycle N+MAX_PERIOD. step_pulse is high for PULSE_W cycles starting the cycle after each step event.
- Step event update, in priority order:
  - rem_new = remaining-1; it is not decremented when run_free.
  - If rem_new==0: go to IDLE and raise done the next cycle.
  - Else if state is ACCEL or CRUISE and rem_new<=ramp_len: go to DECEL, period=min(period+ACCEL_DEC, MAX_PERIOD).
  - Else if ACCEL: period=max(period-ACCEL_DEC, MIN_PERIOD), ramp_len+=1 (saturating). If the new period==MIN_PERIOD, go to CRUISE.
  - Else if DECEL: period=min(period+ACCEL_DEC, MAX_PERIOD).
- stop in ACCEL/CRUISE: remaining=ramp_len, state=DECEL, period+=ACCEL_DEC (saturating), timer not reset.
  - If ramp_len==0: go to IDLE next cycle with done.
  - stop is ignored in DECEL and IDLE.
- start while busy is ignored.
- A pulse in flight when entering IDLE completes its full PULSE_W width.
- All arithmetic is unsigned. The period never leaves [MIN_PERIOD, MAX_PERIOD].

Decomposition:
- Package step_pkg holds:
  - the state enum (IDLE/ACCEL/CRUISE/DECEL)
  - default MIN_PERIOD/MAX_PERIOD/ACCEL_DEC/PULSE_W constants
  - a saturating add/sub function
- Sub-module step_pulse_stretch: registered step event in, PULSE_W-wide step_pulse out, with async reset.

Test Plan (MIN_PERIOD=8, MAX_PERIOD=20, ACCEL_DEC=4, PULSE_W=2, start at cycle 0, hold_en=0):
- steps=1 -> zero_state low cycles 1..20; step event cycle 20; step_pulse high cycles 21-22; done high cycle 21 only; zero_state high from 21.
- steps=10 -> exactly 10 pulses, rising-edge spacing 20(first from start),16,12,8,8,8,8,12,16,20; CRUISE entered after pulse 3, DECEL after pulse 7; one done.
- steps=3 (triangle) -> spacings 20,16,20; CRUISE never entered; done after third pulse.
- run_free=1, stop asserted 1 cycle after pulse 6 -> exactly 3 further pulses spaced 12,16,20; then IDLE, done, zero_state=1.
- start with steps=0, run_free=0 -> no pulses, busy stays 0, no done. Second start during a steps=10 move -> move unaffected, still 10 pulses.
- rst low during a step_pulse high cycle in CRUISE -> step_pulse=0, busy=0, zero_state=1 immediately. After release, start steps=1 repeats the steps=1 timing exactly.
